// File: rtl/pixel_window_alu_if.sv
// Valid/ready bus of pixel_window_alu: operation inputs on one side, results and op_count on the other.
interface pixel_window_alu_if #(
   parameter int PIXEL_W = 8,
   parameter int WIN     = 3,
   parameter int CH      = 3
);
   logic                            in_valid;
   logic                            in_ready;
   logic [2:0]                      opcode;
   logic [WIN*WIN*CH*PIXEL_W-1:0]   cell_a;
   logic [WIN*WIN*CH*PIXEL_W-1:0]   cell_b;
   logic [CH*PIXEL_W-1:0]           user_in;
   logic                            out_valid;
   logic                            out_ready;
   logic [CH*PIXEL_W-1:0]           result;
   logic [15:0]                     op_count;

   modport master (
      output in_valid, opcode, cell_a, cell_b, user_in, out_ready,
      input  in_ready, out_valid, result, op_count
   );

   modport slave (
      input  in_valid, opcode, cell_a, cell_b, user_in, out_ready,
      output in_ready, out_valid, result, op_count
   );
endinterface

// File: rtl/pixel_window_alu.sv
// Two-stage per-channel window ALU (center arithmetic, average, max, min) with valid/ready flow control.
// Define PIXEL_SAT_EN to clamp ADD/ADDI/SUB/SUBI at the pixel range instead of wrapping.
module pixel_window_alu #(
   parameter int PIXEL_W = 8,
   parameter int WIN     = 3,
   parameter int CH      = 3
) (
   input logic               clk,
   input logic               rst,
   pixel_window_alu_if.slave bus
);
   localparam int NPIX     = WIN * WIN;
   localparam int CENTER   = (WIN / 2) * WIN + WIN / 2;
   localparam int SUM_W    = PIXEL_W + $clog2(NPIX);
   localparam int WIN_BITS = NPIX * CH * PIXEL_W;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_ADDI = 3'd1,
      OP_SUB  = 3'd2,
      OP_SUBI = 3'd3,
      OP_AVG  = 3'd4,
      OP_MAX  = 3'd5,
      OP_MIN  = 3'd6,
      OP_PASS = 3'd7
   } opcode_e;

   typedef logic [PIXEL_W-1:0] pix_t;

   logic                        adv;
   logic                        s1Valid_q;
   logic                        s2Valid_q;
   opcode_e                     s1Op_q, s1Op_d;
   logic [CH-1:0][SUM_W-1:0]    s1Sum_q, s1Sum_d;
   logic [CH-1:0][PIXEL_W-1:0]  s1Max_q, s1Max_d;
   logic [CH-1:0][PIXEL_W-1:0]  s1Min_q, s1Min_d;
   logic [CH-1:0][PIXEL_W-1:0]  s1Ac_q, s1Ac_d;
   logic [CH-1:0][PIXEL_W-1:0]  s1Bc_q, s1Bc_d;
   logic [CH-1:0][PIXEL_W-1:0]  s1Imm_q, s1Imm_d;
   logic [CH-1:0][PIXEL_W-1:0]  result_q, result_d;
   logic [15:0]                 opCount_q;

   function automatic pix_t sampleAt(input logic [WIN_BITS-1:0] win, input int k, input int ch);
      return win[(k * CH + ch) * PIXEL_W +: PIXEL_W];
   endfunction

   function automatic pix_t addPix(input pix_t x, input pix_t y);
`ifdef PIXEL_SAT_EN
      logic [PIXEL_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[PIXEL_W] ? '1 : s[PIXEL_W-1:0];
`else
      return x + y;
`endif
   endfunction

   function automatic pix_t subPix(input pix_t x, input pix_t y);
`ifdef PIXEL_SAT_EN
      return (x < y) ? '0 : x - y;
`else
      return x - y;
`endif
   endfunction

   // Both stages move together; a stalled output freezes the whole pipe.
   assign adv           = !s2Valid_q || bus.out_ready;
   assign bus.in_ready  = adv || rst;
   assign bus.out_valid = s2Valid_q;
   assign bus.result    = result_q;
   assign bus.op_count  = opCount_q;

   // Stage 1 reduction: full-width sum plus extrema over the whole window, per channel.
   always_comb begin
      s1Op_d  = opcode_e'(bus.opcode);
      s1Sum_d = '0;
      s1Max_d = '0;
      s1Min_d = '1;
      s1Ac_d  = '0;
      s1Bc_d  = '0;
      s1Imm_d = '0;
      for (int ch = 0; ch < CH; ch++) begin
         s1Ac_d[ch]  = sampleAt(bus.cell_a, CENTER, ch);
         s1Bc_d[ch]  = sampleAt(bus.cell_b, CENTER, ch);
         s1Imm_d[ch] = bus.user_in[ch*PIXEL_W +: PIXEL_W];
         for (int k = 0; k < NPIX; k++) begin
            s1Sum_d[ch] = s1Sum_d[ch] + SUM_W'(sampleAt(bus.cell_a, k, ch));
            if (sampleAt(bus.cell_a, k, ch) > s1Max_d[ch]) begin
               s1Max_d[ch] = sampleAt(bus.cell_a, k, ch);
            end
            if (sampleAt(bus.cell_a, k, ch) < s1Min_d[ch]) begin
               s1Min_d[ch] = sampleAt(bus.cell_a, k, ch);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
      end else if (adv) begin
         s1Valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1Op_q  <= s1Op_d;
            s1Sum_q <= s1Sum_d;
            s1Max_q <= s1Max_d;
            s1Min_q <= s1Min_d;
            s1Ac_q  <= s1Ac_d;
            s1Bc_q  <= s1Bc_d;
            s1Imm_q <= s1Imm_d;
         end
      end
   end

   // Stage 2 selects the final per-channel value from the registered stage-1 terms.
   always_comb begin
      result_d = '0;
      for (int ch = 0; ch < CH; ch++) begin
         case (s1Op_q)
            OP_ADD:  result_d[ch] = addPix(s1Ac_q[ch], s1Bc_q[ch]);
            OP_ADDI: result_d[ch] = addPix(s1Ac_q[ch], s1Imm_q[ch]);
            OP_SUB:  result_d[ch] = subPix(s1Ac_q[ch], s1Bc_q[ch]);
            OP_SUBI: result_d[ch] = subPix(s1Ac_q[ch], s1Imm_q[ch]);
            OP_AVG:  result_d[ch] = PIXEL_W'(s1Sum_q[ch] / SUM_W'(NPIX));
            OP_MAX:  result_d[ch] = s1Max_q[ch];
            OP_MIN:  result_d[ch] = s1Min_q[ch];
            default: result_d[ch] = s1Ac_q[ch];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2Valid_q <= 1'b0;
         result_q  <= '0;
      end else if (adv) begin
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            result_q <= result_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opCount_q <= '0;
      end else if (s2Valid_q && bus.out_ready) begin
         opCount_q <= opCount_q + 16'd1;
      end
   end
endmodule

// File: tb/tb_pixel_window_alu.sv
// Self-checking bench for pixel_window_alu against a plain-arithmetic reference model.
// Honours PIXEL_SAT_EN the same way the design does.
module tb_pixel_window_alu;
   localparam int PW     = 8;
   localparam int W      = 3;
   localparam int C      = 3;
   localparam int NP     = W * W;
   localparam int CENTER = (W / 2) * W + W / 2;
   localparam int MAXV   = (1 << PW) - 1;

   typedef logic [NP*C*PW-1:0] win_t;
   typedef logic [C*PW-1:0]    px_t;

   logic clk = 1'b0;
   logic rst;
   int   tests    = 0;
   int   failed   = 0;
   int   cycleCnt = 0;
   px_t  obsQ[$];
   px_t  expQ[$];
   int   obsCycQ[$];

   pixel_window_alu_if #(.PIXEL_W(PW), .WIN(W), .CH(C)) bus ();

   pixel_window_alu #(.PIXEL_W(PW), .WIN(W), .CH(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   function automatic int getS(input win_t w, input int k, input int ch);
      return int'(w[(k*C+ch)*PW +: PW]);
   endfunction

   function automatic win_t setS(input win_t w, input int k, input int ch, input int v);
      win_t r;
      r = w;
      r[(k*C+ch)*PW +: PW] = PW'(v);
      return r;
   endfunction

   function automatic win_t randWin();
      win_t r;
      r = '0;
      for (int i = 0; i < NP*C; i++) r[i*PW +: PW] = PW'($urandom_range(0, MAXV));
      return r;
   endfunction

   function automatic px_t randPx();
      px_t r;
      r = '0;
      for (int i = 0; i < C; i++) r[i*PW +: PW] = PW'($urandom_range(0, MAXV));
      return r;
   endfunction

   // Reference: integer arithmetic straight from the operation definitions.
   function automatic px_t modelOp(input logic [2:0] op, input win_t a, input win_t b, input px_t imm);
      px_t r;
      r = '0;
      for (int ch = 0; ch < C; ch++) begin
         int ac, bc, iv, v, sum, mx, mn;
         ac  = getS(a, CENTER, ch);
         bc  = getS(b, CENTER, ch);
         iv  = int'(imm[ch*PW +: PW]);
         sum = 0;
         mx  = 0;
         mn  = MAXV;
         for (int k = 0; k < NP; k++) begin
            int s;
            s = getS(a, k, ch);
            sum += s;
            if (s > mx) mx = s;
            if (s < mn) mn = s;
         end
         case (op)
            3'd0:    v = ac + bc;
            3'd1:    v = ac + iv;
            3'd2:    v = ac - bc;
            3'd3:    v = ac - iv;
            3'd4:    v = sum / NP;
            3'd5:    v = mx;
            3'd6:    v = mn;
            default: v = ac;
         endcase
         if (op <= 3'd3) begin
`ifdef PIXEL_SAT_EN
            if (v > MAXV) v = MAXV;
            if (v < 0) v = 0;
`else
            v = v & MAXV;
`endif
         end
         r[ch*PW +: PW] = PW'(v);
      end
      return r;
   endfunction

   // Handshake recorder: negedge sees exactly what the next rising edge will act on.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.in_valid && bus.in_ready)
            expQ.push_back(modelOp(bus.opcode, bus.cell_a, bus.cell_b, bus.user_in));
         if (bus.out_valid && bus.out_ready) begin
            obsQ.push_back(bus.result);
            obsCycQ.push_back(cycleCnt);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] op, input win_t a, input win_t b, input px_t imm);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.cell_a   = a;
      bus.cell_b   = b;
      bus.user_in  = imm;
   endtask

   task automatic resetDut();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      obsQ.delete();
      expQ.delete();
      obsCycQ.delete();
   endtask

   task automatic test_reset();
      win_t a, b;
      px_t  imm, exp;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      step();
      tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      tests++; if (bus.op_count !== 16'd0) begin failed++; $display("[TB] FAIL reset_op_count: got %0d expected 0", bus.op_count); end
      tests++; if (bus.result !== '0) begin failed++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result); end
      tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      obsQ.delete(); expQ.delete(); obsCycQ.delete();
      a = randWin(); b = randWin(); imm = randPx();
      exp = modelOp(3'd7, a, b, imm);
      applyStimulus(3'd7, a, b, imm);
      step();
      bus.in_valid = 1'b0;
      tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL first_accept_early: got %b expected 0", bus.out_valid); end
      step();
      tests++; if (bus.out_valid !== 1'b1) begin failed++; $display("[TB] FAIL first_accept_valid: got %b expected 1", bus.out_valid); end
      tests++; if (bus.result !== exp) begin failed++; $display("[TB] FAIL first_accept_result: got %h expected %h", bus.result, exp); end
      step();
   endtask

   task automatic test_mid_reset();
      logic stale;
      resetDut();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), randWin(), randWin(), randPx());
         step();
      end
      bus.in_valid = 1'b0;
      tests++; if (bus.op_count !== 16'd1) begin failed++; $display("[TB] FAIL midrst_pre_count: got %0d expected 1", bus.op_count); end
      bus.out_ready = 1'b0;
      rst = 1'b1;
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
      step();
      tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
      tests++; if (bus.op_count !== 16'd0) begin failed++; $display("[TB] FAIL midrst_op_count: got %0d expected 0", bus.op_count); end
      rst = 1'b0;
      bus.out_ready = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.out_valid !== 1'b0) stale = 1'b1;
      end
      tests++; if (stale !== 1'b0) begin failed++; $display("[TB] FAIL midrst_stale: got %b expected 0", stale); end
      tests++; if (bus.op_count !== 16'd0) begin failed++; $display("[TB] FAIL midrst_post_count: got %0d expected 0", bus.op_count); end
   endtask

   task automatic test_saturation();
      win_t a, b;
      px_t  imm, exp;
      logic [PW-1:0] want;
      resetDut();
      a = setS(randWin(), CENTER, 0, 200);
      b = setS(randWin(), CENTER, 0, 100);
      imm = randPx();
      exp = modelOp(3'd0, a, b, imm);
`ifdef PIXEL_SAT_EN
      want = 8'd255;
`else
      want = 8'd44;
`endif
      applyStimulus(3'd0, a, b, imm);
      step(); bus.in_valid = 1'b0; step();
      tests++; if (bus.out_valid !== 1'b1) begin failed++; $display("[TB] FAIL add_valid: got %b expected 1", bus.out_valid); end
      tests++; if (bus.result[PW-1:0] !== want) begin failed++; $display("[TB] FAIL add_ch0: got %0d expected %0d", bus.result[PW-1:0], want); end
      tests++; if (bus.result !== exp) begin failed++; $display("[TB] FAIL add_all: got %h expected %h", bus.result, exp); end
      step();
      a = setS(randWin(), CENTER, 0, 10);
      b = randWin();
      imm = randPx();
      imm[PW-1:0] = 8'd20;
      exp = modelOp(3'd3, a, b, imm);
`ifdef PIXEL_SAT_EN
      want = 8'd0;
`else
      want = 8'd246;
`endif
      applyStimulus(3'd3, a, b, imm);
      step(); bus.in_valid = 1'b0; step();
      tests++; if (bus.result[PW-1:0] !== want) begin failed++; $display("[TB] FAIL subi_ch0: got %0d expected %0d", bus.result[PW-1:0], want); end
      tests++; if (bus.result !== exp) begin failed++; $display("[TB] FAIL subi_all: got %h expected %h", bus.result, exp); end
      step();
   endtask

   task automatic test_window_ops();
      win_t a, b;
      px_t  imm, exp;
      int   opsL[4];
      int   wantL[4];
      opsL  = '{4, 5, 6, 7};
      wantL = '{5, 9, 1, 5};
      resetDut();
      a = '0;
      for (int k = 0; k < NP; k++)
         for (int ch = 0; ch < C; ch++) a = setS(a, k, ch, k + 1);
      for (int i = 0; i < 4; i++) begin
         b = randWin(); imm = randPx();
         exp = modelOp(3'(opsL[i]), a, b, imm);
         applyStimulus(3'(opsL[i]), a, b, imm);
         step();
         bus.in_valid = 1'b0;
         tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL win_op%0d_early: got %b expected 0", opsL[i], bus.out_valid); end
         step();
         tests++; if (bus.out_valid !== 1'b1) begin failed++; $display("[TB] FAIL win_op%0d_valid: got %b expected 1", opsL[i], bus.out_valid); end
         tests++; if (int'(bus.result[PW-1:0]) !== wantL[i]) begin failed++; $display("[TB] FAIL win_op%0d_ch0: got %0d expected %0d", opsL[i], bus.result[PW-1:0], wantL[i]); end
         tests++; if (bus.result !== exp) begin failed++; $display("[TB] FAIL win_op%0d_all: got %h expected %h", opsL[i], bus.result, exp); end
         step();
      end
   endtask

   task automatic test_stall();
      win_t a[3], b[3];
      px_t  imm[3], exp[3];
      logic [2:0] op[3];
      int   guard;
      logic unstable;
      resetDut();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         op[i] = 3'($urandom_range(0, 7)); a[i] = randWin(); b[i] = randWin(); imm[i] = randPx();
         exp[i] = modelOp(op[i], a[i], b[i], imm[i]);
      end
      applyStimulus(op[0], a[0], b[0], imm[0]); step();
      applyStimulus(op[1], a[1], b[1], imm[1]); step();
      applyStimulus(op[2], a[2], b[2], imm[2]);
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("[TB] FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
      tests++; if (bus.result !== exp[0]) begin failed++; $display("[TB] FAIL stall_head: got %h expected %h", bus.result, exp[0]); end
      unstable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== exp[0]) unstable = 1'b1;
      end
      tests++; if (unstable !== 1'b0) begin failed++; $display("[TB] FAIL stall_stable: got %b expected 0", unstable); end
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      guard = 0;
      while (obsQ.size() < 3 && guard < 20) begin step(); guard++; end
      step();
      tests++; if (obsQ.size() !== 3) begin failed++; $display("[TB] FAIL stall_count: got %0d expected 3", obsQ.size()); end
      for (int i = 0; i < 3 && i < obsQ.size(); i++) begin
         tests++; if (obsQ[i] !== exp[i]) begin failed++; $display("[TB] FAIL stall_order%0d: got %h expected %h", i, obsQ[i], exp[i]); end
      end
      tests++; if (bus.op_count !== 16'd3) begin failed++; $display("[TB] FAIL stall_op_count: got %0d expected 3", bus.op_count); end
   endtask

   task automatic test_bubble();
      px_t exp0, exp1;
      win_t a0, a1, b0;
      px_t  i0;
      resetDut();
      a0 = randWin(); a1 = randWin(); b0 = randWin(); i0 = randPx();
      exp0 = modelOp(3'd4, a0, b0, i0);
      exp1 = modelOp(3'd5, a1, b0, i0);
      applyStimulus(3'd4, a0, b0, i0); step();
      bus.in_valid = 1'b0; step();
      tests++; if (bus.out_valid !== 1'b1 || bus.result !== exp0) begin failed++; $display("[TB] FAIL bubble_first: got %b/%h expected 1/%h", bus.out_valid, bus.result, exp0); end
      applyStimulus(3'd5, a1, b0, i0); step();
      bus.in_valid = 1'b0;
      tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("[TB] FAIL bubble_gap: got %b expected 0", bus.out_valid); end
      step();
      tests++; if (bus.out_valid !== 1'b1 || bus.result !== exp1) begin failed++; $display("[TB] FAIL bubble_second: got %b/%h expected 1/%h", bus.out_valid, bus.result, exp1); end
      step();
   endtask

   task automatic test_back_to_back();
      int guard, gaps;
      resetDut();
      for (int i = 0; i < 100; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), randWin(), randWin(), randPx());
         step();
      end
      bus.in_valid = 1'b0;
      guard = 0;
      while (obsQ.size() < 100 && guard < 50) begin step(); guard++; end
      step();
      tests++; if (expQ.size() !== 100) begin failed++; $display("[TB] FAIL b2b_accepts: got %0d expected 100", expQ.size()); end
      tests++; if (obsQ.size() !== 100) begin failed++; $display("[TB] FAIL b2b_results: got %0d expected 100", obsQ.size()); end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         tests++; if (obsQ[i] !== expQ[i]) begin failed++; $display("[TB] FAIL b2b_item%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
      end
      gaps = 0;
      for (int i = 1; i < obsCycQ.size(); i++) if (obsCycQ[i] != obsCycQ[i-1] + 1) gaps++;
      tests++; if (gaps !== 0) begin failed++; $display("[TB] FAIL b2b_throughput: got %0d gaps expected 0", gaps); end
      tests++; if (bus.op_count !== 16'd100) begin failed++; $display("[TB] FAIL b2b_op_count: got %0d expected 100", bus.op_count); end
   endtask

   task automatic test_wrap();
      win_t a, b;
      px_t  imm;
      resetDut();
      a = randWin(); b = randWin(); imm = randPx();
      applyStimulus(3'd7, a, b, imm);
      for (int i = 0; i < 65535; i++) step();
      bus.in_valid = 1'b0;
      step(); step(); step();
      tests++; if (bus.op_count !== 16'hFFFF) begin failed++; $display("[TB] FAIL wrap_preload: got %0d expected 65535", bus.op_count); end
      applyStimulus(3'd7, a, b, imm);
      step();
      bus.in_valid = 1'b0;
      step(); step();
      tests++; if (bus.op_count !== 16'd0) begin failed++; $display("[TB] FAIL wrap_rollover: got %0d expected 0", bus.op_count); end
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.opcode    = '0;
      bus.cell_a    = '0;
      bus.cell_b    = '0;
      bus.user_in   = '0;
      test_reset();
      test_mid_reset();
      test_saturation();
      test_window_ops();
      test_stall();
      test_bubble();
      test_back_to_back();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
